// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 serial transmitter with a valid/ready byte input.
// Frame on o_tx: start bit (0), i_data[0] .. i_data[7], stop bit (1).
// Each bit is held for CLKS_PER_BIT clock cycles.
//
// Optional feature, selected by the macro UART_TX_BUFFER_EN:
//   defined   - a one-entry holding buffer accepts the next byte while a
//               frame is in flight, so frames can run back to back.
//   undefined - no buffer; a byte is accepted only in IDLE.
//
// All outputs are registers. o_ready and o_busy are loaded with the value
// that matches the next state, so they track the state with no extra lag.
module uart_transmitter #(
    parameter int unsigned CLKS_PER_BIT = 1395968
) (
    input  logic       clk,
    input  logic       i_reset_n,
    input  logic [0:7] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy
);

    // Last counter value of a bit period; the counter wraps to zero after it.
    localparam logic [23:0] CNT_MAX = 24'(CLKS_PER_BIT - 32'd1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } state_t;

    // Frame state registers and their next-state values.
    state_t      r_state;
    state_t      w_state_next;
    logic [23:0] r_cnt;
    logic [23:0] w_cnt_next;
    logic [2:0]  r_bit_idx;
    logic [2:0]  w_bit_idx_next;
    logic [0:7]  r_data;
    logic [0:7]  w_data_next;
    logic        r_tx;
    logic        w_tx_next;
    logic        r_ready;
    logic        w_ready_next;
    logic        r_busy;
    logic        w_busy_next;

    // Holding-buffer view seen by the frame logic (constant when absent).
    logic        w_buf_full;
    logic [0:7]  w_buf_data;

    logic        w_handshake;
    logic        w_bit_end;

    assign w_handshake = i_valid && r_ready;
    assign w_bit_end   = (r_cnt == CNT_MAX);

    // Next-state, counter, bit-index and shift-register selection.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_bit_idx_next = r_bit_idx;
        w_data_next    = r_data;
        case (r_state)
            IDLE: begin
                w_cnt_next     = 24'd0;
                w_bit_idx_next = 3'd0;
                if (w_buf_full) begin
                    // A byte buffered on the last stop-bit edge starts now.
                    w_data_next  = w_buf_data;
                    w_state_next = START_BIT;
                end else if (w_handshake) begin
                    w_data_next  = i_data;
                    w_state_next = START_BIT;
                end else begin
                    w_state_next = IDLE;
                end
            end
            START_BIT: begin
                if (w_bit_end) begin
                    w_cnt_next     = 24'd0;
                    w_bit_idx_next = 3'd0;
                    w_state_next   = DATA_BITS;
                end else begin
                    w_cnt_next = r_cnt + 24'd1;
                end
            end
            DATA_BITS: begin
                if (w_bit_end) begin
                    w_cnt_next = 24'd0;
                    if (r_bit_idx == 3'd7) begin
                        w_bit_idx_next = 3'd0;
                        w_state_next   = STOP_BIT;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 24'd1;
                end
            end
            STOP_BIT: begin
                if (w_bit_end) begin
                    w_cnt_next     = 24'd0;
                    w_bit_idx_next = 3'd0;
                    if (w_buf_full) begin
                        // Chain straight into the next frame, no idle cycle.
                        w_data_next  = w_buf_data;
                        w_state_next = START_BIT;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt + 24'd1;
                end
            end
            default: begin
                w_cnt_next     = 24'd0;
                w_bit_idx_next = 3'd0;
                w_state_next   = IDLE;
            end
        endcase
    end

    // Line level for the next cycle, so o_tx changes on the state's first edge.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            IDLE:      w_tx_next = 1'b1;
            START_BIT: w_tx_next = 1'b0;
            DATA_BITS: w_tx_next = w_data_next[w_bit_idx_next];
            STOP_BIT:  w_tx_next = 1'b1;
            default:   w_tx_next = 1'b1;
        endcase
    end

`ifdef UART_TX_BUFFER_EN
    logic [0:7] r_buf;
    logic       r_buf_full;
    logic       w_fill_buf;
    logic       w_load_buf;
    logic       w_buf_full_next;

    // Any handshake outside IDLE parks the byte in the buffer.
    assign w_fill_buf      = w_handshake && (r_state != IDLE);
    // The buffer drains into the shift register when a new frame starts from it.
    assign w_load_buf      = r_buf_full &&
                             ((r_state == IDLE) || ((r_state == STOP_BIT) && w_bit_end));
    assign w_buf_full_next = w_fill_buf ? 1'b1 : (w_load_buf ? 1'b0 : r_buf_full);
    assign w_buf_full      = r_buf_full;
    assign w_buf_data      = r_buf;
    assign w_ready_next    = !w_buf_full_next;
    assign w_busy_next     = (w_state_next != IDLE) || w_buf_full_next;

    // Holding buffer: a fill on the same edge as a drain keeps the new byte.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_buf      <= 8'h00;
            r_buf_full <= 1'b0;
        end else if (w_fill_buf) begin
            r_buf      <= i_data;
            r_buf_full <= 1'b1;
        end else if (w_load_buf) begin
            r_buf_full <= 1'b0;
        end else begin
            r_buf_full <= r_buf_full;
        end
    end
`else
    assign w_buf_full   = 1'b0;
    assign w_buf_data   = 8'h00;
    assign w_ready_next = (w_state_next == IDLE);
    assign w_busy_next  = (w_state_next != IDLE);
`endif

    // Frame state and registered outputs; reset drops any frame in flight.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= 24'd0;
            r_bit_idx <= 3'd0;
            r_data    <= 8'h00;
            r_tx      <= 1'b1;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_data    <= w_data_next;
            r_tx      <= w_tx_next;
            r_ready   <= w_ready_next;
            r_busy    <= w_busy_next;
        end
    end

    assign o_tx    = r_tx;
    assign o_ready = r_ready;
    assign o_busy  = r_busy;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: scoreboard bench for uart_transmitter at CLKS_PER_BIT=4.
// Expected line levels are pushed to a queue when a byte is handed over and
// popped one per cycle while o_tx is sampled on the falling clock edge.
module tb_uart_transmitter;

    localparam int CPB = 4;

`ifdef UART_TX_BUFFER_EN
    localparam int IDLE_GAP = 0;   // idle cycles between chained frames
    localparam int ACCEPT2  = 1;   // sample index at which the 2nd byte is taken
`else
    localparam int IDLE_GAP = 1;
    localparam int ACCEPT2  = 41;
`endif

    logic       clk       = 1'b0;
    logic       i_reset_n = 1'b1;
    logic       i_valid   = 1'b0;
    logic [0:7] i_data    = 8'h00;
    logic       o_ready;
    logic       o_tx;
    logic       o_busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic q_exp[$];
    logic exp_bit;

    uart_transmitter #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .i_reset_n (i_reset_n),
        .i_data    (i_data),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .o_tx      (o_tx),
        .o_busy    (o_busy)
    );

    always #5 clk = ~clk;

    function automatic void push_bits(input logic v, input int cycles);
        for (int i = 0; i < cycles; i++) q_exp.push_back(v);
    endfunction

    function automatic void push_frame(input logic [0:7] d);
        push_bits(1'b0, CPB);
        for (int i = 0; i < 8; i++) push_bits(d[i], CPB);
        push_bits(1'b1, CPB);
    endfunction

    task automatic test_reset();
        #2 i_reset_n = 1'b0;
        #1;
        n_tests++; if (o_tx !== 1'b1)    begin n_fail++; $display("FAIL reset_tx: got %b want 1", o_tx); end
        n_tests++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        n_tests++; if (o_busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        repeat (3) @(negedge clk);
        i_reset_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            n_tests++; if (o_tx !== 1'b1) begin n_fail++; $display("FAIL reset_idle_tx cycle %0d: got %b want 1", n, o_tx); end
        end
    endtask

    task automatic test_single();
        logic [0:7] d = 8'b10100101;
        q_exp.delete();
        push_frame(d);
        @(negedge clk);
        i_data  = d;
        i_valid = 1'b1;
        n_tests++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", o_ready); end
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin i_valid = 1'b0; i_data = 8'h5A; end
            exp_bit = q_exp.pop_front();
            n_tests++; if (o_tx !== exp_bit) begin n_fail++; $display("FAIL single_tx cycle %0d: got %b want %b", n, o_tx, exp_bit); end
            n_tests++; if (o_busy !== 1'b1)  begin n_fail++; $display("FAIL single_busy cycle %0d: got %b want 1", n, o_busy); end
        end
        @(negedge clk);
        n_tests++; if (o_tx !== 1'b1)    begin n_fail++; $display("FAIL single_end_tx: got %b want 1", o_tx); end
        n_tests++; if (o_busy !== 1'b0)  begin n_fail++; $display("FAIL single_end_busy: got %b want 0", o_busy); end
        n_tests++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL single_end_ready: got %b want 1", o_ready); end
    endtask

    task automatic test_back_to_back();
        int stage   = 1;
        int acc2    = -1;
        bit pending = 1'b0;
        int total   = 80 + IDLE_GAP;
        q_exp.delete();
        push_frame(8'h00);
        push_bits(1'b1, IDLE_GAP);
        push_frame(8'hFF);
        @(negedge clk);
        i_data  = 8'h00;
        i_valid = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= total; n++) begin
            @(negedge clk);
            if (pending) begin pending = 1'b0; stage++; i_valid = 1'b0; end
            if (n == 1) i_data = 8'hFF;
            exp_bit = q_exp.pop_front();
            n_tests++; if (o_tx !== exp_bit) begin n_fail++; $display("FAIL b2b_tx cycle %0d: got %b want %b", n, o_tx, exp_bit); end
            if (i_valid && o_ready && !pending && stage == 1) begin pending = 1'b1; acc2 = n; end
        end
        n_tests++; if (acc2 !== ACCEPT2) begin n_fail++; $display("FAIL b2b_accept_cycle: got %0d want %0d", acc2, ACCEPT2); end
        i_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (o_tx !== 1'b1)   begin n_fail++; $display("FAIL b2b_end_tx: got %b want 1", o_tx); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end_busy: got %b want 0", o_busy); end
    endtask

`ifndef UART_TX_BUFFER_EN
    task automatic test_busy_reject();
        logic [0:7] d = 8'b11010010;
        q_exp.delete();
        push_frame(d);
        @(negedge clk);
        i_data  = d;
        i_valid = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) i_valid = 1'b0;
            if (n == 18) i_valid = 1'b0;
            if (n == 17) begin
                i_valid = 1'b1;
                i_data  = 8'h33;
                n_tests++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL reject_ready: got %b want 0", o_ready); end
            end
            exp_bit = q_exp.pop_front();
            n_tests++; if (o_tx !== exp_bit) begin n_fail++; $display("FAIL reject_tx cycle %0d: got %b want %b", n, o_tx, exp_bit); end
        end
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            n_tests++; if (o_tx !== 1'b1)   begin n_fail++; $display("FAIL reject_idle_tx cycle %0d: got %b want 1", n, o_tx); end
            n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reject_idle_busy cycle %0d: got %b want 0", n, o_busy); end
        end
    endtask
`else
    task automatic test_buffer_full();
        int stage   = 1;
        int acc2    = -1;
        int acc3    = -1;
        bit pending = 1'b0;
        q_exp.delete();
        push_frame(8'h0F);
        push_frame(8'hC3);
        push_frame(8'h96);
        @(negedge clk);
        i_data  = 8'h0F;
        i_valid = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 120; n++) begin
            @(negedge clk);
            if (pending) begin
                pending = 1'b0;
                stage++;
                if (stage == 2) i_data = 8'h96;
                else i_valid = 1'b0;
            end
            if (n == 1) i_data = 8'hC3;
            exp_bit = q_exp.pop_front();
            n_tests++; if (o_tx !== exp_bit) begin n_fail++; $display("FAIL buf_tx cycle %0d: got %b want %b", n, o_tx, exp_bit); end
            if (n == 2 || n == 40) begin
                n_tests++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL buf_full_ready cycle %0d: got %b want 0", n, o_ready); end
            end
            if (i_valid && o_ready && !pending) begin
                pending = 1'b1;
                if (stage == 1) acc2 = n;
                else acc3 = n;
            end
        end
        n_tests++; if (acc2 !== 1)  begin n_fail++; $display("FAIL buf_accept2: got %0d want 1", acc2); end
        n_tests++; if (acc3 !== 41) begin n_fail++; $display("FAIL buf_accept3: got %0d want 41", acc3); end
        i_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL buf_end_busy: got %b want 0", o_busy); end
    endtask
`endif

    task automatic test_reset_mid_frame();
        logic [0:7] d  = 8'hE1;
        logic [0:7] d2 = 8'hA5;
        q_exp.delete();
        push_frame(d);
        @(negedge clk);
        i_data  = d;
        i_valid = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 18; n++) begin
            @(negedge clk);
            if (n == 1) i_valid = 1'b0;
            exp_bit = q_exp.pop_front();
            n_tests++; if (o_tx !== exp_bit) begin n_fail++; $display("FAIL midrst_pre_tx cycle %0d: got %b want %b", n, o_tx, exp_bit); end
        end
        i_reset_n = 1'b0;
        #1;
        n_tests++; if (o_tx !== 1'b1)    begin n_fail++; $display("FAIL midrst_tx: got %b want 1", o_tx); end
        n_tests++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", o_ready); end
        n_tests++; if (o_busy !== 1'b0)  begin n_fail++; $display("FAIL midrst_busy: got %b want 0", o_busy); end
        q_exp.delete();
        repeat (2) @(negedge clk);
        i_reset_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            n_tests++; if (o_tx !== 1'b1) begin n_fail++; $display("FAIL midrst_idle_tx cycle %0d: got %b want 1", n, o_tx); end
        end
        push_frame(d2);
        i_data  = d2;
        i_valid = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) i_valid = 1'b0;
            exp_bit = q_exp.pop_front();
            n_tests++; if (o_tx !== exp_bit) begin n_fail++; $display("FAIL midrst_post_tx cycle %0d: got %b want %b", n, o_tx, exp_bit); end
        end
        @(negedge clk);
        n_tests++; if (o_busy !== 1'b0)  begin n_fail++; $display("FAIL midrst_end_busy: got %b want 0", o_busy); end
        n_tests++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_end_ready: got %b want 1", o_ready); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
`ifndef UART_TX_BUFFER_EN
        test_busy_reject();
`else
        test_buffer_full();
`endif
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Upper bound on run time in case the sequence above ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
